// File: rtl/vx_decode_ibuf.sv
// Decode-side instruction buffer: per-warp FIFOs feeding the issue stage through a
// round-robin warp arbiter with grant lock. Define IBUF_OUT_REG_EN to register issue_*.
module vx_decode_ibuf #(
  parameter int unsigned NUM_WARPS = 4,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned DATAW     = 64,
  localparam int unsigned WIDW     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int unsigned PTRW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNTW     = PTRW + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 decode_valid,
  input  logic [WIDW-1:0]      decode_wid,
  input  logic [DATAW-1:0]     decode_data,
  output logic                 decode_ready,
  output logic [NUM_WARPS-1:0] ibuf_pop,
  output logic                 issue_valid,
  output logic [WIDW-1:0]      issue_wid,
  output logic [DATAW-1:0]     issue_data,
  input  logic                 issue_ready
);

  logic [DATAW-1:0]     mem_q   [NUM_WARPS][DEPTH];
  logic [PTRW-1:0]      wptr_q  [NUM_WARPS];
  logic [PTRW-1:0]      rptr_q  [NUM_WARPS];
  logic [CNTW-1:0]      count_q [NUM_WARPS];
  logic [WIDW-1:0]      last_wid_q, lock_wid_q;
  logic                 lock_q;
  logic [NUM_WARPS-1:0] ibuf_pop_q;

  logic                 decode_fire;
  logic                 sel_valid;
  logic [WIDW-1:0]      sel_wid, rr_idx;
  logic [DATAW-1:0]     head_data;
  logic                 deq, lock_hold;
  logic [NUM_WARPS-1:0] push_oh, pop_oh;

  // Full warps refuse even when popping this cycle: no push-through.
  assign decode_ready = (count_q[decode_wid] < CNTW'(DEPTH)) & reset_n;
  assign decode_fire  = decode_valid & decode_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_wid   = lock_wid_q;
    rr_idx    = '0;
    if (lock_q) begin
      sel_valid = 1'b1;
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        rr_idx = WIDW'((int'(last_wid_q) + 1 + i) % int'(NUM_WARPS));
        if (!sel_valid && count_q[rr_idx] != '0) begin
          sel_valid = 1'b1;
          sel_wid   = rr_idx;
        end
      end
    end
  end

  assign head_data = mem_q[sel_wid][rptr_q[sel_wid]];

`ifdef IBUF_OUT_REG_EN
  logic             out_valid_q;
  logic [WIDW-1:0]  out_wid_q;
  logic [DATAW-1:0] out_data_q;

  assign deq       = sel_valid & (~out_valid_q | issue_ready);
  assign lock_hold = sel_valid & ~deq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_wid_q   <= '0;
      out_data_q  <= '0;
    end else if (~out_valid_q | issue_ready) begin
      out_valid_q <= sel_valid;
      if (deq) begin
        out_wid_q  <= sel_wid;
        out_data_q <= head_data;
      end
    end
  end

  assign issue_valid = out_valid_q;
  assign issue_wid   = out_wid_q;
  assign issue_data  = out_data_q;
`else
  assign deq         = sel_valid & issue_ready;
  assign lock_hold   = sel_valid & ~issue_ready;
  assign issue_valid = sel_valid;
  assign issue_wid   = sel_wid;
  assign issue_data  = head_data;
`endif

  always_comb begin
    push_oh = '0;
    pop_oh  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      push_oh[w] = decode_fire && (decode_wid == WIDW'(w));
      pop_oh[w]  = deq && (sel_wid == WIDW'(w));
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (decode_fire) begin
      mem_q[decode_wid][wptr_q[decode_wid]] <= decode_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        wptr_q[w]  <= '0;
        rptr_q[w]  <= '0;
        count_q[w] <= '0;
      end
      last_wid_q <= WIDW'(NUM_WARPS - 1);
      lock_q     <= 1'b0;
      lock_wid_q <= '0;
      ibuf_pop_q <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (push_oh[w]) wptr_q[w] <= wptr_q[w] + PTRW'(1);
        if (pop_oh[w])  rptr_q[w] <= rptr_q[w] + PTRW'(1);
        unique case ({push_oh[w], pop_oh[w]})
          2'b10:   count_q[w] <= count_q[w] + CNTW'(1);
          2'b01:   count_q[w] <= count_q[w] - CNTW'(1);
          default: count_q[w] <= count_q[w];
        endcase
      end
      ibuf_pop_q <= pop_oh;
      if (deq) begin
        last_wid_q <= sel_wid;
        lock_q     <= 1'b0;
      end else if (lock_hold) begin
        lock_q     <= 1'b1;
        lock_wid_q <= sel_wid;
      end
    end
  end

  assign ibuf_pop = ibuf_pop_q;

endmodule

// File: doc/vx_decode_ibuf.md
# VX_decode_ibuf

Receiving end of the decode interface. It accepts decoded instructions from the decode stage into per-warp instruction FIFOs and issues them one per cycle to the issue stage through a round-robin warp arbiter. It drives `ready` and the per-warp `ibuf_pop` credit pulses that decode and fetch use to throttle each warp.

## Interface
- NUM_WARPS, 4: number of warps; each warp has its own FIFO (≥2).
- DEPTH, 2: entries per warp FIFO (≥2, power of 2).
- DATAW, 64: width of the flattened `decode_t` payload, excluding `wid`.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- decode_valid  in  1  decode entry valid.
- decode_wid  in  log2(NUM_WARPS)  warp id of the entry.
- decode_data  in  DATAW  decoded payload.
- decode_ready  out  1  entry accepted when high with decode_valid.
- ibuf_pop  out  NUM_WARPS  one-cycle pulse per entry dequeued, one bit per warp.
- issue_valid  out  1  issue entry valid.
- issue_wid  out  log2(NUM_WARPS)  warp id of the issued entry.
- issue_data  out  DATAW  issued payload.
- issue_ready  in  1  issue stage accepts.

## Operation
- Push: `decode_fire = decode_valid & decode_ready` writes `decode_data` at `wptr[decode_wid]`, then increments that pointer (wraps modulo DEPTH) and `count[decode_wid]`.
- `decode_ready = (count[decode_wid] < DEPTH) & reset_n`.
- A full warp is not ready, even if the same warp pops in that cycle. There is no push-through.
- Counts are log2(DEPTH)+1 bits wide.
- Arbiter candidates are the warps with `count > 0`.
- Priority is round-robin, starting at `(last_wid + 1) mod NUM_WARPS`.
- `last_wid` updates to the dequeued warp on each dequeue.
- Grant lock: when the head is presented and not taken, the granted warp is registered as `lock_wid` and the lock is set. While locked, the arbiter selects `lock_wid`. The lock clears on dequeue.
- Dequeue (`deq`) removes the head of the selected warp: `rptr` increments with wrap and `count` decrements.
- When the same warp is pushed and popped in one cycle, `count` is unchanged and both pointers advance.
- `ibuf_pop[w]` is high the cycle after a dequeue from warp w. It never has more than one bit set.
- Reset (reset_n low, at any time including mid-transfer) has these effects:
  - All counts and pointers go to 0, and `last_wid` goes to NUM_WARPS-1, so warp 0 has first priority.
  - The lock clears, and `issue_valid`, `ibuf_pop` and `decode_ready` are all 0.
  - FIFO storage is not reset, and in-flight entries are discarded.

## Timing
- Latency from decode accept to `issue_valid` is 1 cycle, or 2 with IBUF_OUT_REG_EN.
- Sustained throughput is 1 issue per cycle when any warp is non-empty and `issue_ready` is high.
- Handshake: once `issue_valid` is high, `issue_valid`, `issue_wid` and `issue_data` stay stable until `issue_ready`.
- `issue_valid` must not depend combinationally on `issue_ready`.
- `decode_ready` depends combinationally on `decode_wid` and the counts only.

## Configuration
- IBUF_OUT_REG_EN undefined:
  - `issue_*` is driven combinationally from the arbiter-selected FIFO head.
  - `deq = issue_valid & issue_ready`.
- IBUF_OUT_REG_EN defined:
  - A registered output stage sits between the arbiter and `issue_*`.
  - `deq` occurs when the stage is empty or being drained (`!out_valid | issue_ready`) and a candidate exists.
  - The stage loads the head on `deq`; `issue_*` come from the registers.
  - Full throughput is preserved.
  - `ibuf_pop` tracks the FIFO dequeue, not the issue handshake.
  - Reset clears `out_valid`.

## Test plan
- Reset mid-stream: fill warp 1 with 2 entries, assert reset_n=0 for 1 cycle -> `issue_valid=0`, `ibuf_pop=0`, `decode_ready=0` during reset; after release, `decode_ready=1` for all wids and no stale entries issue.
- Full/backpressure: DEPTH=2, `issue_ready=0`, push 3 entries to warp 2 -> third is refused (`decode_ready=0`); a push to warp 0 in the same period is accepted.
- Round-robin: preload 1 entry in each of warps 0–3, then `issue_ready=1` -> `issue_wid` sequence 0,1,2,3 on consecutive cycles; `ibuf_pop` = 0001,0010,0100,1000, each lagging one cycle.
- Grant lock: warp 1 presented with `issue_ready=0` for 3 cycles while warp 0 receives an entry -> `issue_wid` stays 1 with stable `issue_data` until accepted; warp 0 issues next.
- Simultaneous push/pop: warp 3 holds 1 entry, push and dequeue warp 3 in the same cycle -> `count[3]` stays 1, in-order data, pointer wrap verified over 8 entries.
- Latency: single push to empty warp 0 -> `issue_valid` 1 cycle later without IBUF_OUT_REG_EN, 2 cycles later with it.
